// File: rtl/divider8_pkg.sv
// Shared widths, iteration count and FSM state encoding for the divider8 slice.
package divider8_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int ITER       = DIVIDEND_W;
  localparam int CNT_W      = $clog2(ITER) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider8_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract the divisor.
module divider8_step
  import divider8_pkg::*;
(
  input  logic [DIVISOR_W-1:0] rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] b_i,
  output logic [DIVISOR_W-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIVISOR_W:0] s;
  logic               ge;

  // S is at most 2*b-1, so the difference always fits back into DIVISOR_W bits
  always_comb begin
    s       = {rem_i, bit_i};
    ge      = (s >= {1'b0, b_i});
    q_bit_o = ge;
    rem_o   = ge ? DIVISOR_W'(s - {1'b0, b_i}) : s[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/divider8.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Optional DIVIDER8_EARLY_EXIT_EN: p < b (b != 0) completes straight from the start edge.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | iterating, one quotient bit per edge (busy = 1)
// DONE  | results valid, done pulses for one cycle; a start here is taken as the next operation
module divider8
  import divider8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] p,
  input  logic [DIVISOR_W-1:0]  b,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  div0
);

  div_state_t            state_q, state_d;
  logic [DIVIDEND_W-1:0] shift_q, shift_d;
  logic [DIVISOR_W-1:0]  b_q, b_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic                  div0_q, div0_d;

  logic [DIVISOR_W-1:0]  rem_nxt;
  logic                  q_bit;
  logic                  accept;
  logic                  b_zero;
  logic                  early_hit;
  logic                  last_iter;

  divider8_step u_step (
    .rem_i   (rem_q),
    .bit_i   (shift_q[DIVIDEND_W-1]),
    .b_i     (b_q),
    .rem_o   (rem_nxt),
    .q_bit_o (q_bit)
  );

  // DONE re-accepts start so back-to-back operations sustain one per ITER+1 cycles
  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign b_zero    = (b == '0);
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));

`ifdef DIVIDER8_EARLY_EXIT_EN
  assign early_hit = !b_zero && ({{(DIVIDEND_W-DIVISOR_W){1'b0}}, b} > p);
`else
  assign early_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (b_zero || early_hit) state_d = DONE;
          else                     state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN:     if (last_iter) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    b_d     = b_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    if (accept) begin
      shift_d = p;
      b_d     = b;
      rem_d   = '0;
      cnt_d   = '0;
      div0_d  = 1'b0;
      if (b_zero) begin
        q_d    = '1;
        r_d    = p[DIVISOR_W-1:0];
        div0_d = 1'b1;
      end else if (early_hit) begin
        q_d = '0;
        r_d = p[DIVISOR_W-1:0];
      end
    end else if (state_q == RUN) begin
      // quotient bits shift in behind the dividend bits being consumed
      shift_d = {shift_q[DIVIDEND_W-2:0], q_bit};
      rem_d   = rem_nxt;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last_iter) begin
        q_d = {shift_q[DIVIDEND_W-2:0], q_bit};
        r_d = rem_nxt;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    q    = q_q;
    r    = r_q;
    div0 = div0_q;
  end

endmodule

// File: tb/tb_divider8.sv
// Directed and randomised checks of divider8 against hand-computed values and p/b, p%b.
module tb_divider8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] p;
  logic [7:0]  b;
  logic        busy, done, div0;
  logic [15:0] q;
  logic [7:0]  r;

  int n_tests = 0;
  int n_fail  = 0;

  divider8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .div0  (div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; leaves the bench #1 after the edge where done is seen.
  task automatic run_op(input logic [15:0] pp, input logic [7:0] bb,
                        output int lat, output int busy_cnt);
    p = pp; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, exp_lat, seen;
    logic [15:0] rp;
    logic [7:0]  rb;

    rst = 1'b1; start = 1'b0; p = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q",    q,    0);
    check("reset_r",    r,    0);
    check("reset_div0", div0, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 61*66 recovered
    run_op(16'd4026, 8'd66, lat, bcnt);
    check("f61_done", done, 1);
    check("f61_lat", lat, 16);
    check("f61_busy_cycles", bcnt, 16);
    check("f61_q", q, 61);
    check("f61_r", r, 0);
    check("f61_div0", div0, 0);
    @(posedge clk); #1;
    check("f61_done_pulse", done, 0);
    check("f61_q_hold", q, 61);

    run_op(16'hFFFF, 8'd1, lat, bcnt);
    check("ffff_q", q, 16'hFFFF);
    check("ffff_r", r, 0);
    // back-to-back from DONE
    run_op(16'd1000, 8'd7, lat, bcnt);
    check("b2b_lat", lat, 16);
    check("k1000_q", q, 142);
    check("k1000_r", r, 6);

    // divide by zero
    @(posedge clk); #1;
    run_op(16'h1234, 8'd0, lat, bcnt);
    check("dz_done", done, 1);
    check("dz_lat", lat, 0);
    check("dz_busy", bcnt, 0);
    check("dz_q", q, 16'hFFFF);
    check("dz_r", r, 8'h34);
    check("dz_div0", div0, 1);
    @(posedge clk); #1;
    check("dz_div0_hold", div0, 1);
    run_op(16'd100, 8'd10, lat, bcnt);
    check("dz_clear_div0", div0, 0);
    check("dz_clear_q", q, 10);

    // start during RUN at edge N+5 is ignored
    @(posedge clk); #1;
    p = 16'd4026; b = 8'd66; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    p = 16'd9; b = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    check("ign_lat", lat, 16);
    check("ign_q", q, 61);
    check("ign_r", r, 0);

    // reset at edge N+5 aborts
    @(posedge clk); #1;
    p = 16'd4026; b = 8'd66; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_r", r, 0);
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) seen++; end
    check("rst_no_done", seen, 0);

    // p < b
`ifdef DIVIDER8_EARLY_EXIT_EN
    exp_lat = 0;
`else
    exp_lat = 16;
`endif
    run_op(16'd5, 8'd9, lat, bcnt);
    check("small_lat", lat, exp_lat);
    check("small_q", q, 0);
    check("small_r", r, 5);

    // rst together with start: reset wins
    @(posedge clk); #1;
    p = 16'd500; b = 8'd5; start = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_done", done, 0);
    @(posedge clk); #1;

    // randomised back-to-back sweep
    for (int i = 0; i < 1000; i++) begin
      rp = 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(1, 255));
      if (i % 8 == 0) rp = 16'(rb * 8'($urandom_range(0, 255)));
      run_op(rp, rb, lat, bcnt);
      check("sweep_done", done, 1);
      check("sweep_qr_div0", {q, r, div0}, {rp / {8'd0, rb}, 8'(rp % {8'd0, rb}), 1'b0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
